id_ex_stage: RTL and testbench

- Decode stage plus ID/EX pipeline register for the 64-bit RV64I core; sits directly downstream of the register file.
- Drives register-file read addresses from the ID instruction and captures ReadData1/ReadData2, immediate and control into the EX stage.
- Adds write-back bypass, because the register file does not reflect a same-edge write on an unchanged read address.
- Detects load-use hazards, inserts bubbles, honours branch flush and keeps a saturating stall counter.

---
 rtl/id_ex_stage.sv | 196 +++++++++++++++++++
 tb/tb_id_ex_stage.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_stage.sv
// Decode stage and ID/EX pipeline register for the RV64I core.
// Decodes the ID instruction, applies write-back bypass to the register-file
// read data, detects load-use hazards and registers everything into EX.
module id_ex_stage #(
  parameter int XLEN  = 64,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             valid_id,
  input  logic [31:0]      instr_id,
  input  logic [XLEN-1:0]  pc_id,
  input  logic             flush,
  input  logic [XLEN-1:0]  ReadData1,
  input  logic [XLEN-1:0]  ReadData2,
  input  logic             wb_reg_write,
  input  logic [4:0]       wb_rd,
  input  logic [XLEN-1:0]  wb_data,
  output logic [4:0]       RS1,
  output logic [4:0]       RS2,
  output logic             stall,
  output logic             valid_ex,
  output logic             reg_write_ex,
  output logic             mem_read_ex,
  output logic             mem_write_ex,
  output logic             branch_ex,
  output logic             alu_src_ex,
  output logic             mem_to_reg_ex,
  output logic [1:0]       alu_op_ex,
  output logic [2:0]       funct3_ex,
  output logic             funct7b5_ex,
  output logic [4:0]       rs1_ex,
  output logic [4:0]       rs2_ex,
  output logic [4:0]       rd_ex,
  output logic [XLEN-1:0]  pc_ex,
  output logic [XLEN-1:0]  rs1_data_ex,
  output logic [XLEN-1:0]  rs2_data_ex,
  output logic [XLEN-1:0]  imm_ex,
  output logic             illegal_ex,
  output logic [CNT_W-1:0] stall_count
);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I_ALU  = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  typedef struct packed {
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       branch;
    logic       alu_src;
    logic       mem_to_reg;
    logic       illegal;
    logic [1:0] alu_op;
    logic       use_rs1;
    logic       use_rs2;
  } ctrl_t;

  ctrl_t           dec;
  logic [XLEN-1:0] imm;
  logic [XLEN-1:0] rs1_val;
  logic [XLEN-1:0] rs2_val;
  logic            capture;

  assign RS1 = instr_id[19:15];
  assign RS2 = instr_id[24:20];

  // Opcode decode: control bits, source usage and sign-extended immediate.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // through the case can leave a value unassigned and infer a latch.
    dec = '0;
    imm = '0;
    unique case (instr_id[6:0])
      OP_R: begin
        dec.reg_write = 1'b1;
        dec.alu_op    = 2'b10;
        dec.use_rs1   = 1'b1;
        dec.use_rs2   = 1'b1;
      end
      OP_I_ALU: begin
        dec.reg_write = 1'b1;
        dec.alu_src   = 1'b1;
        dec.alu_op    = 2'b11;
        dec.use_rs1   = 1'b1;
        imm = {{(XLEN-12){instr_id[31]}}, instr_id[31:20]};
      end
      OP_LOAD: begin
        dec.reg_write  = 1'b1;
        dec.mem_read   = 1'b1;
        dec.mem_to_reg = 1'b1;
        dec.alu_src    = 1'b1;
        dec.use_rs1    = 1'b1;
        imm = {{(XLEN-12){instr_id[31]}}, instr_id[31:20]};
      end
      OP_STORE: begin
        dec.mem_write = 1'b1;
        dec.alu_src   = 1'b1;
        dec.use_rs1   = 1'b1;
        dec.use_rs2   = 1'b1;
        imm = {{(XLEN-12){instr_id[31]}}, instr_id[31:25], instr_id[11:7]};
      end
      OP_BRANCH: begin
        dec.branch  = 1'b1;
        dec.alu_op  = 2'b01;
        dec.use_rs1 = 1'b1;
        dec.use_rs2 = 1'b1;
        imm = {{(XLEN-13){instr_id[31]}}, instr_id[31], instr_id[7],
               instr_id[30:25], instr_id[11:8], 1'b0};
      end
      default: dec.illegal = 1'b1;
    endcase
  end

  // Operand select: x0 is hard zero, then the same-cycle WB write wins over
  // the register file, which would otherwise return the stale value.
  always_comb begin
    rs1_val = ReadData1;
    rs2_val = ReadData2;
    if (RS1 == 5'd0)
      rs1_val = '0;
    else if (wb_reg_write && (wb_rd == RS1))
      rs1_val = wb_data;
    if (RS2 == 5'd0)
      rs2_val = '0;
    else if (wb_reg_write && (wb_rd == RS2))
      rs2_val = wb_data;
  end

  // Load-use hazard: the load in EX has no data yet for a dependent ID
  // instruction. A flush kills the ID instruction, so it never stalls.
  always_comb begin
    stall = valid_ex && mem_read_ex && (rd_ex != 5'd0) &&
            (((rd_ex == RS1) && dec.use_rs1) || ((rd_ex == RS2) && dec.use_rs2)) &&
            valid_id && !flush;
  end

  assign capture = valid_id && !flush && !stall;

  // ID/EX register: capture the decoded instruction or load a bubble.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (reset || !capture) begin
      valid_ex      <= 1'b0;
      reg_write_ex  <= 1'b0;
      mem_read_ex   <= 1'b0;
      mem_write_ex  <= 1'b0;
      branch_ex     <= 1'b0;
      alu_src_ex    <= 1'b0;
      mem_to_reg_ex <= 1'b0;
      alu_op_ex     <= 2'b00;
      funct3_ex     <= 3'b000;
      funct7b5_ex   <= 1'b0;
      rs1_ex        <= 5'd0;
      rs2_ex        <= 5'd0;
      rd_ex         <= 5'd0;
      pc_ex         <= '0;
      rs1_data_ex   <= '0;
      rs2_data_ex   <= '0;
      imm_ex        <= '0;
      illegal_ex    <= 1'b0;
    end else begin
      valid_ex      <= 1'b1;
      reg_write_ex  <= dec.reg_write;
      mem_read_ex   <= dec.mem_read;
      mem_write_ex  <= dec.mem_write;
      branch_ex     <= dec.branch;
      alu_src_ex    <= dec.alu_src;
      mem_to_reg_ex <= dec.mem_to_reg;
      alu_op_ex     <= dec.alu_op;
      funct3_ex     <= instr_id[14:12];
      funct7b5_ex   <= instr_id[30];
      rs1_ex        <= RS1;
      rs2_ex        <= RS2;
      rd_ex         <= instr_id[11:7];
      pc_ex         <= pc_id;
      rs1_data_ex   <= rs1_val;
      rs2_data_ex   <= rs2_val;
      imm_ex        <= imm;
      illegal_ex    <= dec.illegal;
    end
  end

  // Saturating stall-cycle counter, cleared only by reset.
  always_ff @(posedge clk) begin
    if (reset)
      stall_count <= '0;
    else if (stall && (stall_count != {CNT_W{1'b1}}))
      stall_count <= stall_count + CNT_W'(1);
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed testbench for id_ex_stage: decode, bypass, load-use stall,
// flush, illegal opcode, counter saturation and reset during a stall.
module tb_id_ex_stage;

  localparam int XLEN  = 64;
  localparam int CNT_W = 3;

  localparam logic [31:0] I_ADDI    = 32'hFFD08293; // addi x5,x1,-3
  localparam logic [31:0] I_ADDI6   = 32'h00608293; // addi x5,x1,6 (rs2 field = 6)
  localparam logic [31:0] I_LD6     = 32'h00013303; // ld x6,0(x2)
  localparam logic [31:0] I_LD0     = 32'h00013003; // ld x0,0(x2)
  localparam logic [31:0] I_ADD_DEP = 32'h003303B3; // add x7,x6,x3
  localparam logic [31:0] I_ADD_IND = 32'h003203B3; // add x7,x4,x3
  localparam logic [31:0] I_ADD_X0  = 32'h003003B3; // add x7,x0,x3
  localparam logic [31:0] I_SD_DEP  = 32'h00613423; // sd x6,8(x2)
  localparam logic [31:0] I_SUB     = 32'h40A48433; // sub x8,x9,x10
  localparam logic [31:0] I_SD_NEG  = 32'hFE513E23; // sd x5,-4(x2)
  localparam logic [31:0] I_BEQ     = 32'hFE208CE3; // beq x1,x2,-8
  localparam logic [31:0] I_ILL     = 32'h0000007F;

  // {valid, reg_write, mem_read, mem_write, branch, alu_src, mem_to_reg, illegal, alu_op}
  localparam logic [9:0] C_BUBBLE = 10'b0000000000;
  localparam logic [9:0] C_LOAD   = 10'b1110011000;
  localparam logic [9:0] C_IALU   = 10'b1100010011;
  localparam logic [9:0] C_R      = 10'b1100000010;
  localparam logic [9:0] C_STORE  = 10'b1001010000;
  localparam logic [9:0] C_BRANCH = 10'b1000100001;
  localparam logic [9:0] C_ILL    = 10'b1000000100;

  logic             clk = 1'b0;
  logic             reset;
  logic             valid_id;
  logic [31:0]      instr_id;
  logic [XLEN-1:0]  pc_id;
  logic             flush;
  logic [XLEN-1:0]  ReadData1, ReadData2;
  logic             wb_reg_write;
  logic [4:0]       wb_rd;
  logic [XLEN-1:0]  wb_data;
  logic [4:0]       RS1, RS2;
  logic             stall;
  logic             valid_ex, reg_write_ex, mem_read_ex, mem_write_ex;
  logic             branch_ex, alu_src_ex, mem_to_reg_ex;
  logic [1:0]       alu_op_ex;
  logic [2:0]       funct3_ex;
  logic             funct7b5_ex;
  logic [4:0]       rs1_ex, rs2_ex, rd_ex;
  logic [XLEN-1:0]  pc_ex, rs1_data_ex, rs2_data_ex, imm_ex;
  logic             illegal_ex;
  logic [CNT_W-1:0] stall_count;
  logic [9:0]       ctl;
  logic [CNT_W-1:0] cnt_before;

  int checks   = 0;
  int failures = 0;

  assign ctl = {valid_ex, reg_write_ex, mem_read_ex, mem_write_ex, branch_ex,
                alu_src_ex, mem_to_reg_ex, illegal_ex, alu_op_ex};

  id_ex_stage #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .valid_id(valid_id), .instr_id(instr_id),
    .pc_id(pc_id), .flush(flush), .ReadData1(ReadData1), .ReadData2(ReadData2),
    .wb_reg_write(wb_reg_write), .wb_rd(wb_rd), .wb_data(wb_data),
    .RS1(RS1), .RS2(RS2), .stall(stall), .valid_ex(valid_ex),
    .reg_write_ex(reg_write_ex), .mem_read_ex(mem_read_ex),
    .mem_write_ex(mem_write_ex), .branch_ex(branch_ex), .alu_src_ex(alu_src_ex),
    .mem_to_reg_ex(mem_to_reg_ex), .alu_op_ex(alu_op_ex), .funct3_ex(funct3_ex),
    .funct7b5_ex(funct7b5_ex), .rs1_ex(rs1_ex), .rs2_ex(rs2_ex), .rd_ex(rd_ex),
    .pc_ex(pc_ex), .rs1_data_ex(rs1_data_ex), .rs2_data_ex(rs2_data_ex),
    .imm_ex(imm_ex), .illegal_ex(illegal_ex), .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  // Advance past the next rising edge; outputs are sampled 1 time unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] ins);
    valid_id = v;
    instr_id = ins;
  endtask

  task automatic do_reset();
    reset = 1'b1; valid_id = 1'b1; instr_id = I_ADDI; flush = 1'b0;
    pc_id = 64'h40; ReadData1 = 64'h1234; ReadData2 = 64'h5678;
    wb_reg_write = 1'b0; wb_rd = 5'd0; wb_data = '0;
    tick(); tick();
    reset = 1'b0; valid_id = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (ctl !== C_BUBBLE) begin failures++; $display("FAIL reset_ctl got=%b exp=%b", ctl, C_BUBBLE); end
    checks++; if (imm_ex !== '0 || pc_ex !== '0 || rs1_data_ex !== '0 || rs2_data_ex !== '0) begin
      failures++; $display("FAIL reset_data got imm=%h pc=%h r1=%h r2=%h exp=0", imm_ex, pc_ex, rs1_data_ex, rs2_data_ex); end
    checks++; if (rd_ex !== 5'd0 || stall_count !== '0 || stall !== 1'b0) begin
      failures++; $display("FAIL reset_misc got rd=%0d cnt=%0d stall=%b exp=0", rd_ex, stall_count, stall); end
  endtask

  task automatic test_addi();
    do_reset();
    drive(1'b1, I_ADDI); pc_id = 64'h100; ReadData1 = 64'd1;
    #1;
    checks++; if (RS1 !== 5'd1 || RS2 !== 5'd29) begin failures++; $display("FAIL addi_rs_addr got=%0d,%0d exp=1,29", RS1, RS2); end
    tick();
    checks++; if (ctl !== C_IALU) begin failures++; $display("FAIL addi_ctl got=%b exp=%b", ctl, C_IALU); end
    checks++; if (imm_ex !== 64'hFFFF_FFFF_FFFF_FFFD) begin failures++; $display("FAIL addi_imm got=%h exp=fffffffffffffffd", imm_ex); end
    checks++; if (rs1_data_ex !== 64'd1 || rd_ex !== 5'd5 || rs1_ex !== 5'd1 || pc_ex !== 64'h100) begin
      failures++; $display("FAIL addi_fields got r1=%h rd=%0d rs1=%0d pc=%h exp=1,5,1,100", rs1_data_ex, rd_ex, rs1_ex, pc_ex); end
  endtask

  task automatic test_load_use();
    do_reset();
    drive(1'b1, I_LD6);
    tick();
    checks++; if (ctl !== C_LOAD || rd_ex !== 5'd6) begin failures++; $display("FAIL ld_ctl got=%b rd=%0d exp=%b rd=6", ctl, rd_ex, C_LOAD); end
    drive(1'b1, I_ADD_DEP);
    #1;
    checks++; if (stall !== 1'b1) begin failures++; $display("FAIL lu_stall got=%b exp=1", stall); end
    tick();
    checks++; if (valid_ex !== 1'b0 || stall !== 1'b0) begin failures++; $display("FAIL lu_bubble got valid=%b stall=%b exp=0,0", valid_ex, stall); end
    checks++; if (stall_count !== 3'd1) begin failures++; $display("FAIL lu_count got=%0d exp=1", stall_count); end
    tick();
    checks++; if (ctl !== C_R || rd_ex !== 5'd7 || rs1_ex !== 5'd6 || rs2_ex !== 5'd3) begin
      failures++; $display("FAIL lu_capture got=%b rd=%0d rs=%0d,%0d exp=%b 7 6,3", ctl, rd_ex, rs1_ex, rs2_ex, C_R); end
    checks++; if (stall_count !== 3'd1) begin failures++; $display("FAIL lu_count_hold got=%0d exp=1", stall_count); end
  endtask

  task automatic test_no_hazard();
    do_reset();
    drive(1'b1, I_LD6); tick();
    drive(1'b1, I_ADD_IND); #1;
    checks++; if (stall !== 1'b0) begin failures++; $display("FAIL nh_indep got=%b exp=0", stall); end
    drive(1'b1, I_ADDI6); #1;
    checks++; if (stall !== 1'b0) begin failures++; $display("FAIL nh_rs2_unused got=%b exp=0", stall); end
    drive(1'b1, I_SD_DEP); #1;
    checks++; if (stall !== 1'b1) begin failures++; $display("FAIL nh_store_rs2 got=%b exp=1", stall); end
    drive(1'b0, I_ADD_DEP); #1;
    checks++; if (stall !== 1'b0) begin failures++; $display("FAIL nh_invalid_id got=%b exp=0", stall); end
    drive(1'b1, I_LD0); tick();
    drive(1'b1, I_ADD_X0); #1;
    checks++; if (stall !== 1'b0) begin failures++; $display("FAIL nh_x0 got=%b exp=0", stall); end
  endtask

  task automatic test_bypass();
    do_reset();
    drive(1'b1, I_SUB); ReadData1 = 64'd9; ReadData2 = 64'h22;
    wb_reg_write = 1'b1; wb_rd = 5'd9; wb_data = 64'hDEAD;
    tick();
    checks++; if (rs1_data_ex !== 64'hDEAD || rs2_data_ex !== 64'h22) begin
      failures++; $display("FAIL byp_rs1 got=%h,%h exp=dead,22", rs1_data_ex, rs2_data_ex); end
    checks++; if (funct7b5_ex !== 1'b1 || funct3_ex !== 3'd0 || ctl !== C_R) begin
      failures++; $display("FAIL byp_sub_ctl got f7b5=%b f3=%0d ctl=%b exp=1,0,%b", funct7b5_ex, funct3_ex, ctl, C_R); end
    wb_rd = 5'd10; wb_data = 64'hBEEF;
    tick();
    checks++; if (rs1_data_ex !== 64'd9 || rs2_data_ex !== 64'hBEEF) begin
      failures++; $display("FAIL byp_rs2 got=%h,%h exp=9,beef", rs1_data_ex, rs2_data_ex); end
    wb_reg_write = 1'b0; wb_rd = 5'd9;
    tick();
    checks++; if (rs1_data_ex !== 64'd9) begin failures++; $display("FAIL byp_nowrite got=%h exp=9", rs1_data_ex); end
    drive(1'b1, I_ADD_X0); wb_reg_write = 1'b1; wb_rd = 5'd0; wb_data = 64'hDEAD;
    ReadData1 = 64'h55; ReadData2 = 64'h33;
    tick();
    checks++; if (rs1_data_ex !== 64'd0 || rs2_data_ex !== 64'h33) begin
      failures++; $display("FAIL byp_x0 got=%h,%h exp=0,33", rs1_data_ex, rs2_data_ex); end
    wb_reg_write = 1'b0;
  endtask

  task automatic test_flush();
    do_reset();
    drive(1'b1, I_LD6); tick();
    cnt_before = stall_count;
    drive(1'b1, I_ADD_DEP); flush = 1'b1; #1;
    checks++; if (stall !== 1'b0) begin failures++; $display("FAIL fl_stall got=%b exp=0", stall); end
    tick();
    checks++; if (ctl !== C_BUBBLE || stall_count !== cnt_before) begin
      failures++; $display("FAIL fl_bubble got ctl=%b cnt=%0d exp=%b cnt=%0d", ctl, stall_count, C_BUBBLE, cnt_before); end
    flush = 1'b0;
  endtask

  task automatic test_store_branch_illegal();
    do_reset();
    drive(1'b1, I_SD_NEG); tick();
    checks++; if (ctl !== C_STORE || imm_ex !== 64'hFFFF_FFFF_FFFF_FFFC || funct3_ex !== 3'd3) begin
      failures++; $display("FAIL sd_decode got ctl=%b imm=%h f3=%0d exp=%b fffffffffffffffc 3", ctl, imm_ex, funct3_ex, C_STORE); end
    drive(1'b1, I_BEQ); tick();
    checks++; if (ctl !== C_BRANCH || imm_ex !== 64'hFFFF_FFFF_FFFF_FFF8) begin
      failures++; $display("FAIL beq_decode got ctl=%b imm=%h exp=%b fffffffffffffff8", ctl, imm_ex, C_BRANCH); end
    drive(1'b1, I_ILL); tick();
    checks++; if (ctl !== C_ILL || imm_ex !== '0) begin
      failures++; $display("FAIL illegal got ctl=%b imm=%h exp=%b 0", ctl, imm_ex, C_ILL); end
    drive(1'b0, I_ILL); tick();
    checks++; if (ctl !== C_BUBBLE) begin failures++; $display("FAIL invalid_bubble got=%b exp=%b", ctl, C_BUBBLE); end
  endtask

  task automatic test_saturation();
    do_reset();
    for (int i = 0; i < 9; i++) begin
      drive(1'b1, I_LD6); tick();
      drive(1'b1, I_ADD_DEP); tick(); tick();
    end
    checks++; if (stall_count !== 3'd7) begin failures++; $display("FAIL sat_count got=%0d exp=7", stall_count); end
  endtask

  task automatic test_reset_mid_stall();
    do_reset();
    drive(1'b1, I_LD6); tick();
    drive(1'b1, I_ADD_DEP); tick(); tick();
    drive(1'b1, I_LD6); tick();
    drive(1'b1, I_ADD_DEP); #1;
    checks++; if (stall !== 1'b1 || stall_count !== 3'd1) begin
      failures++; $display("FAIL rms_pre got stall=%b cnt=%0d exp=1,1", stall, stall_count); end
    reset = 1'b1;
    tick();
    checks++; if (ctl !== C_BUBBLE || stall_count !== '0 || stall !== 1'b0 || rd_ex !== 5'd0 || imm_ex !== '0) begin
      failures++; $display("FAIL rms_post got ctl=%b cnt=%0d stall=%b rd=%0d imm=%h exp=0", ctl, stall_count, stall, rd_ex, imm_ex); end
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; valid_id = 1'b0; instr_id = '0; pc_id = '0; flush = 1'b0;
    ReadData1 = '0; ReadData2 = '0; wb_reg_write = 1'b0; wb_rd = '0; wb_data = '0;
    test_reset();
    test_addi();
    test_load_use();
    test_no_hazard();
    test_bypass();
    test_flush();
    test_store_branch_illegal();
    test_saturation();
    test_reset_mid_stall();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
